slim_freeze_ctrl: RTL and testbench
===================================

Name: slim_freeze_ctrl

Overview:
- Upstream controller for the slime sprite renderer. It decides when a slime is frozen, when it is shattered, and when it damages the player.
- Compares the player's ice projectile box and the player body box against the slime's 34x33 box, on the shared 60 Hz game tick (ipcnt == TICK_VAL).
- Drives the renderer's slim_frozen input and reports hit/kill events to the game-state logic.
- One instance per slime.

Parameters:
TICK_VAL, 6000000, ipcnt value that marks one game tick
FREEZE_TICKS, 127, ticks a slime stays frozen; equals the renderer's frozen-animation wrap length
IMMUNE_TICKS, 16, ticks after thawing during which ice passes through
SLIM_W, 34, slime box width in pixels
SLIM_H, 33, slime box height
ICE_W, 16, ice projectile box width
ICE_H, 16, ice projectile box height
PLY_W, 32, player box width
PLY_H, 40, player box height

Ports:
clk  in  1  system clock, same as the renderer's
rst  in  1  asynchronous active-high reset
ipcnt  in  32  free-running game counter; tick when ipcnt == TICK_VAL
x_slim  in  10  slime box left edge, from the renderer
y_slim  in  9  slime box top edge, from the renderer
ice_valid  in  1  ice projectile in flight
ice_x  in  10  projectile left edge
ice_y  in  9  projectile top edge
ply_x  in  10  player left edge
ply_y  in  9  player top edge
slim_frozen  out  1  to the renderer; 1 while in state FROZEN
slim_visible  out  1  0 once the slime is shattered
ice_consume  out  1  one-cycle pulse: the projectile hit this slime and must be removed
player_hit  out  1  one-cycle pulse: the walking or immune slime touched the player
slim_dead  out  1  sticky shatter flag
frz_left  out  7  remaining frozen ticks; 0 outside FROZEN
freeze_cnt  out  8  number of freezes, saturating at 255

Behaviour:
- Reset values (asynchronous, active-high): state WALK, slim_frozen 0, slim_visible 1, ice_consume 0, player_hit 0, slim_dead 0, frz_left 0, freeze_cnt 0, all internal registers 0.
- Tick: tick = (ipcnt == TICK_VAL), evaluated combinationally every cycle.
- Overlap rule: boxes are inclusive, A spans ax..ax+aw-1.
  - Overlap requires ax <= bx+bw-1, bx <= ax+aw-1, and the same for y.
  - All sums are computed 11-bit (x) and 10-bit (y), so no wrap occurs at screen edges.
- Stage 1 (registered):
  - hit_ice = ice_valid & overlap(ice, slime).
  - hit_ply = overlap(player, slime).
  - hit_ply_d = previous hit_ply.
- Stage 2 (state update): outputs change on the second clock edge after an input change, so latency is 2 cycles.
- touch = hit_ply & ~hit_ply_d. This is a rising-edge event, so sustained contact damages the player only once.
- State WALK:
  - hit_ice → FROZEN; frz_left = FREEZE_TICKS; ice_consume pulse; freeze_cnt += 1 (saturating).
  - else touch → player_hit pulse.
  - If hit_ice and touch occur in the same cycle, the freeze wins and player_hit is not asserted.
- State FROZEN: slim_frozen = 1. Priority order:
  - 1. hit_ply (level, not edge) → DEAD.
  - 2. hit_ice → frz_left reloads to FREEZE_TICKS; ice_consume pulse; freeze_cnt does not increment.
  - 3. tick → frz_left -= 1. On the tick where frz_left == 1: go to IMMUNE, frz_left = 0, imm_left = IMMUNE_TICKS.
  - A reload and a tick in the same cycle: the reload wins.
- State IMMUNE:
  - ice is ignored; there is no ice_consume.
  - touch → player_hit pulse.
  - tick → imm_left -= 1. On the tick where imm_left == 1 → WALK.
- State DEAD: slim_frozen 0, slim_visible 0, slim_dead 1. The block ignores all inputs until reset.
- Pulse rules:
  - ice_consume and player_hit are never high for more than one cycle per event.
  - They are never high in the same cycle.
- Reset asserted mid-FROZEN: slim_frozen drops to 0 asynchronously; slim_visible returns to 1.

Decomposition:
- Package slim_pkg holds:
  - the state enum {WALK, FROZEN, IMMUNE, DEAD};
  - the default constants TICK_VAL, FREEZE_TICKS, IMMUNE_TICKS and the box sizes;
  - the screen width constants 640/480.
- One sub-module, slim_box_overlap:
  - parameterised by AW, AH, BW, BH;
  - combinational inclusive-box compare with widened arithmetic;
  - instantiated twice, for ice and for player.
- FSM, tick counters and edge detection stay in the top module.

Test Plan:
- Freeze: slime at (240,277), ice at (250,280), ice_valid=1 for one cycle → ice_consume pulses 2 cycles later, slim_frozen=1, frz_left=127, freeze_cnt=1.
- Thaw: from FROZEN, apply 127 ticks with no hits → slim_frozen falls on the 127th tick, and the slime enters IMMUNE. Ice at (250,280) during the next 16 ticks gives no ice_consume. After 16 ticks, the same ice freezes again and freeze_cnt=2.
- Refreeze: frozen with frz_left=10; ice hit coincident with a tick → frz_left=127, no freeze_cnt change.
- Shatter and contact damage:
  - Player at (230,270) while FROZEN → slim_dead=1, slim_visible=0, slim_frozen=0; later ice hits give no response.
  - In WALK, the player held overlapping for 100 cycles → exactly one player_hit pulse.
- Boundaries:
  - Ice at x=x_slim+34 → no hit; ice at x=x_slim+33 → hit.
  - Slime at x=620 near the right edge → no false overlap from wrap.
  - Ice hit and touch in the same cycle in WALK → freeze only, no player_hit.
  - rst mid-FROZEN → all outputs return to reset values immediately.

Source files
------------

// File: rtl/slim_pkg.sv
// Shared types and default constants for the slime freeze controller.
package slim_pkg;

  // Slime behaviour states
  typedef enum logic [1:0] {
    WALK,
    FROZEN,
    IMMUNE,
    DEAD
  } slim_state_e;

  // One 60 Hz game tick is marked by this ipcnt value
  localparam logic [31:0] TICK_VAL = 32'd6000000;

  // Frozen duration matches the renderer's frozen-animation wrap length
  localparam int FREEZE_TICKS = 127;
  localparam int IMMUNE_TICKS = 16;

  // Box sizes in pixels
  localparam int SLIM_W = 34;
  localparam int SLIM_H = 33;
  localparam int ICE_W  = 16;
  localparam int ICE_H  = 16;
  localparam int PLY_W  = 32;
  localparam int PLY_H  = 40;

  // Visible screen size
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Increment that sticks at the top of an 8-bit range
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/slim_box_overlap.sv
// Inclusive axis-aligned box overlap test between box A and box B.
// Edge sums are widened by one bit so boxes near the coordinate limit never wrap.
module slim_box_overlap #(
  parameter int AW = 16,
  parameter int AH = 16,
  parameter int BW = 34,
  parameter int BH = 33
) (
  input  logic [9:0] i_ax,
  input  logic [8:0] i_ay,
  input  logic [9:0] i_bx,
  input  logic [8:0] i_by,
  output logic       o_overlap
);

  logic [10:0] w_axEnd;
  logic [10:0] w_bxEnd;
  logic [9:0]  w_ayEnd;
  logic [9:0]  w_byEnd;

  // Last pixel covered by each box, one bit wider than the coordinates
  assign w_axEnd = {1'b0, i_ax} + 11'(AW - 1);
  assign w_bxEnd = {1'b0, i_bx} + 11'(BW - 1);
  assign w_ayEnd = {1'b0, i_ay} + 10'(AH - 1);
  assign w_byEnd = {1'b0, i_by} + 10'(BH - 1);

  // Each box must start no later than the other one ends, on both axes
  assign o_overlap = ({1'b0, i_ax} <= w_bxEnd) &&
                     ({1'b0, i_bx} <= w_axEnd) &&
                     ({1'b0, i_ay} <= w_byEnd) &&
                     ({1'b0, i_by} <= w_ayEnd);

endmodule

// File: rtl/slim_freeze_ctrl.sv
// Per-slime controller: decides freezing, shattering and contact damage.
// Stage 1 registers the box hits, stage 2 runs the state machine, so hit
// responses appear two clock edges after the inputs change.
module slim_freeze_ctrl #(
  parameter logic [31:0] TICK_VAL     = slim_pkg::TICK_VAL,
  parameter int          FREEZE_TICKS = slim_pkg::FREEZE_TICKS,
  parameter int          IMMUNE_TICKS = slim_pkg::IMMUNE_TICKS,
  parameter int          SLIM_W       = slim_pkg::SLIM_W,
  parameter int          SLIM_H       = slim_pkg::SLIM_H,
  parameter int          ICE_W        = slim_pkg::ICE_W,
  parameter int          ICE_H        = slim_pkg::ICE_H,
  parameter int          PLY_W        = slim_pkg::PLY_W,
  parameter int          PLY_H        = slim_pkg::PLY_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ipcnt,
  input  logic [9:0]  x_slim,
  input  logic [8:0]  y_slim,
  input  logic        ice_valid,
  input  logic [9:0]  ice_x,
  input  logic [8:0]  ice_y,
  input  logic [9:0]  ply_x,
  input  logic [8:0]  ply_y,
  output logic        slim_frozen,
  output logic        slim_visible,
  output logic        ice_consume,
  output logic        player_hit,
  output logic        slim_dead,
  output logic [6:0]  frz_left,
  output logic [7:0]  freeze_cnt
);

  import slim_pkg::*;

  localparam logic [6:0] FRZ_LOAD = 7'(FREEZE_TICKS);
  localparam logic [4:0] IMM_LOAD = 5'(IMMUNE_TICKS);

  logic        w_tick;
  logic        w_iceOverlap;
  logic        w_plyOverlap;
  logic        w_touch;

  logic        r_hitIce;
  logic        r_hitPly;
  logic        r_hitPlyD;

  slim_state_e r_state;
  logic [4:0]  r_immLeft;
  logic        r_frozen;
  logic        r_visible;
  logic        r_iceConsume;
  logic        r_playerHit;
  logic        r_dead;
  logic [6:0]  r_frzLeft;
  logic [7:0]  r_freezeCnt;

  assign w_tick = (ipcnt == TICK_VAL);

  slim_box_overlap #(
    .AW(ICE_W), .AH(ICE_H), .BW(SLIM_W), .BH(SLIM_H)
  ) u_iceBox (
    .i_ax      (ice_x),
    .i_ay      (ice_y),
    .i_bx      (x_slim),
    .i_by      (y_slim),
    .o_overlap (w_iceOverlap)
  );

  slim_box_overlap #(
    .AW(PLY_W), .AH(PLY_H), .BW(SLIM_W), .BH(SLIM_H)
  ) u_plyBox (
    .i_ax      (ply_x),
    .i_ay      (ply_y),
    .i_bx      (x_slim),
    .i_by      (y_slim),
    .o_overlap (w_plyOverlap)
  );

  // Stage 1: register box hits and keep last cycle's player contact for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hitIce  <= 1'b0;
      r_hitPly  <= 1'b0;
      r_hitPlyD <= 1'b0;
    end else begin
      r_hitIce  <= ice_valid & w_iceOverlap;
      r_hitPly  <= w_plyOverlap;
      r_hitPlyD <= r_hitPly;
    end
  end

  // Only a fresh contact damages the player, not sustained overlap
  assign w_touch = r_hitPly & ~r_hitPlyD;

  // Stage 2: slime state machine with registered outputs and tick counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WALK;
      r_immLeft    <= 5'd0;
      r_frozen     <= 1'b0;
      r_visible    <= 1'b1;
      r_iceConsume <= 1'b0;
      r_playerHit  <= 1'b0;
      r_dead       <= 1'b0;
      r_frzLeft    <= 7'd0;
      r_freezeCnt  <= 8'd0;
    end else begin
      r_iceConsume <= 1'b0;
      r_playerHit  <= 1'b0;
      case (r_state)
        WALK: begin
          if (r_hitIce) begin
            r_state      <= FROZEN;
            r_frozen     <= 1'b1;
            r_frzLeft    <= FRZ_LOAD;
            r_iceConsume <= 1'b1;
            r_freezeCnt  <= satInc8(r_freezeCnt);
          end else if (w_touch) begin
            r_playerHit <= 1'b1;
          end
        end
        FROZEN: begin
          if (r_hitPly) begin
            r_state   <= DEAD;
            r_frozen  <= 1'b0;
            r_visible <= 1'b0;
            r_dead    <= 1'b1;
            r_frzLeft <= 7'd0;
          end else if (r_hitIce) begin
            r_frzLeft    <= FRZ_LOAD;
            r_iceConsume <= 1'b1;
          end else if (w_tick) begin
            if (r_frzLeft == 7'd1) begin
              r_state   <= IMMUNE;
              r_frozen  <= 1'b0;
              r_frzLeft <= 7'd0;
              r_immLeft <= IMM_LOAD;
            end else begin
              r_frzLeft <= r_frzLeft - 7'd1;
            end
          end
        end
        IMMUNE: begin
          if (w_touch) begin
            r_playerHit <= 1'b1;
          end
          if (w_tick) begin
            if (r_immLeft == 5'd1) begin
              r_state   <= WALK;
              r_immLeft <= 5'd0;
            end else begin
              r_immLeft <= r_immLeft - 5'd1;
            end
          end
        end
        DEAD: begin
        end
        default: begin
          r_state <= WALK;
        end
      endcase
    end
  end

  assign slim_frozen  = r_frozen;
  assign slim_visible = r_visible;
  assign ice_consume  = r_iceConsume;
  assign player_hit   = r_playerHit;
  assign slim_dead    = r_dead;
  assign frz_left     = r_frzLeft;
  assign freeze_cnt   = r_freezeCnt;

endmodule

// File: tb/tb_slim_freeze_ctrl.sv
// Self-checking bench for slim_freeze_ctrl. Expected output words are queued
// when stimulus is driven and popped as the DUT reaches each cycle.
module tb_slim_freeze_ctrl;

  localparam logic [31:0] TICK = 32'd6000000;

  logic        clk;
  logic        rst;
  logic [31:0] ipcnt;
  logic [9:0]  x_slim;
  logic [8:0]  y_slim;
  logic        ice_valid;
  logic [9:0]  ice_x;
  logic [8:0]  ice_y;
  logic [9:0]  ply_x;
  logic [8:0]  ply_y;
  logic        slim_frozen;
  logic        slim_visible;
  logic        ice_consume;
  logic        player_hit;
  logic        slim_dead;
  logic [6:0]  frz_left;
  logic [7:0]  freeze_cnt;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } exp_t;

  exp_t sbQ[$];
  int   vectorsApplied = 0;
  int   miscompares    = 0;

  slim_freeze_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ipcnt        (ipcnt),
    .x_slim       (x_slim),
    .y_slim       (y_slim),
    .ice_valid    (ice_valid),
    .ice_x        (ice_x),
    .ice_y        (ice_y),
    .ply_x        (ply_x),
    .ply_y        (ply_y),
    .slim_frozen  (slim_frozen),
    .slim_visible (slim_visible),
    .ice_consume  (ice_consume),
    .player_hit   (player_hit),
    .slim_dead    (slim_dead),
    .frz_left     (frz_left),
    .freeze_cnt   (freeze_cnt)
  );

  // 10 ns free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: frozen, visible, consume, player_hit, dead, frz_left, freeze_cnt
  function automatic logic [19:0] outVec();
    return {slim_frozen, slim_visible, ice_consume, player_hit, slim_dead, frz_left, freeze_cnt};
  endfunction

  function automatic logic [19:0] mk(input logic f, input logic vis, input logic c,
                                     input logic h, input logic d,
                                     input logic [6:0] fl, input logic [7:0] fc);
    return {f, vis, c, h, d, fl, fc};
  endfunction

  task automatic expectNext(input string tag, input logic [19:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbQ.push_back(e);
  endtask

  // Advance n clock edges; returns 1 ns after the last rising edge
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    ipcnt     = 32'd0;
    x_slim    = 10'd240;
    y_slim    = 9'd277;
    ice_valid = 1'b0;
    ice_x     = 10'd0;
    ice_y     = 9'd0;
    ply_x     = 10'd0;
    ply_y     = 9'd0;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    setIdle();
    rst = 1'b1;
    applyStimulus(2);
    expectNext("reset_held", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
    rst = 1'b0;
    expectNext("reset_released", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
    applyStimulus(1);
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    ice_x     = 10'd250;
    ice_y     = 9'd280;
    ice_valid = 1'b1;
    expectNext("freeze_lat1", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
    expectNext("freeze_hit", mk(1, 1, 1, 0, 0, 7'd127, 8'd1));
    expectNext("freeze_hold", mk(1, 1, 0, 0, 0, 7'd127, 8'd1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      ice_valid = 1'b0;
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
      end
    end
  endtask

  task automatic test_thaw();
    exp_t e;
    ipcnt = TICK;
    expectNext("thaw_tick126", mk(1, 1, 0, 0, 0, 7'd1, 8'd1));
    applyStimulus(126);
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
    expectNext("thaw_tick127", mk(0, 1, 0, 0, 0, 7'd0, 8'd1));
    applyStimulus(1);
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
    ice_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expectNext("immune_ice_ignored", mk(0, 1, 0, 0, 0, 7'd0, 8'd1));
      applyStimulus(1);
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]: observed %h expected %h", e.tag, i, outVec(), e.v);
      end
    end
    ice_valid = 1'b0;
    ipcnt     = 32'd0;
    expectNext("refreeze_after_immune", mk(1, 1, 1, 0, 0, 7'd127, 8'd2));
    expectNext("refreeze_hold", mk(1, 1, 0, 0, 0, 7'd127, 8'd2));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
      end
    end
  endtask

  task automatic test_refreeze();
    exp_t e;
    ipcnt = TICK;
    expectNext("count_down_to_10", mk(1, 1, 0, 0, 0, 7'd10, 8'd2));
    applyStimulus(117);
    ipcnt = 32'd0;
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
    ice_valid = 1'b1;
    expectNext("reload_lat1", mk(1, 1, 0, 0, 0, 7'd10, 8'd2));
    expectNext("reload_with_tick", mk(1, 1, 1, 0, 0, 7'd127, 8'd2));
    expectNext("reload_hold", mk(1, 1, 0, 0, 0, 7'd127, 8'd2));
    applyStimulus(1);
    ice_valid = 1'b0;
    ipcnt     = TICK;
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      ipcnt = 32'd0;
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
      end
    end
  endtask

  task automatic test_shatter();
    exp_t e;
    ply_x = 10'd230;
    ply_y = 9'd270;
    expectNext("shatter_lat1", mk(1, 1, 0, 0, 0, 7'd127, 8'd2));
    expectNext("shatter", mk(0, 0, 0, 0, 1, 7'd0, 8'd2));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
      end
    end
    ply_x     = 10'd0;
    ply_y     = 9'd0;
    ice_valid = 1'b1;
    ipcnt     = TICK;
    for (int i = 0; i < 6; i++) begin
      expectNext("dead_ignores_inputs", mk(0, 0, 0, 0, 1, 7'd0, 8'd2));
      applyStimulus(1);
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]: observed %h expected %h", e.tag, i, outVec(), e.v);
      end
    end
    setIdle();
  endtask

  task automatic test_reset_mid_frozen();
    exp_t e;
    doReset();
    ice_x     = 10'd250;
    ice_y     = 9'd280;
    ice_valid = 1'b1;
    applyStimulus(1);
    ice_valid = 1'b0;
    expectNext("frozen_before_reset", mk(1, 1, 0, 0, 0, 7'd127, 8'd1));
    applyStimulus(2);
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
    #2;
    rst = 1'b1;
    expectNext("async_reset_mid_frozen", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
    #1;
    e = sbQ.pop_front();
    vectorsApplied++;
    if (outVec() !== e.v) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
    end
    applyStimulus(1);
    rst = 1'b0;
    setIdle();
  endtask

  task automatic test_contact();
    exp_t e;
    int   pulses;
    doReset();
    pulses = 0;
    ply_x  = 10'd230;
    ply_y  = 9'd270;
    for (int i = 1; i <= 100; i++) begin
      expectNext("contact_hold", (i == 2) ? mk(0, 1, 0, 1, 0, 7'd0, 8'd0)
                                          : mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
      applyStimulus(1);
      if (player_hit === 1'b1) pulses++;
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]: observed %h expected %h", e.tag, i, outVec(), e.v);
      end
    end
    vectorsApplied++;
    if (pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL contact_pulse_count: observed %0d expected 1", pulses);
    end
    setIdle();
  endtask

  task automatic test_boundary_x();
    exp_t e;
    doReset();
    ice_x     = 10'd274;
    ice_y     = 9'd280;
    ice_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expectNext("ice_at_x_plus_34", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
      applyStimulus(1);
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]: observed %h expected %h", e.tag, i, outVec(), e.v);
      end
    end
    ice_x = 10'd273;
    expectNext("ice_x33_lat1", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
    expectNext("ice_at_x_plus_33", mk(1, 1, 1, 0, 0, 7'd127, 8'd1));
    expectNext("ice_x33_hold", mk(1, 1, 0, 0, 0, 7'd127, 8'd1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      ice_valid = 1'b0;
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
      end
    end
  endtask

  task automatic test_edge_wrap();
    exp_t e;
    doReset();
    x_slim    = 10'd620;
    y_slim    = 9'd490;
    ice_x     = 10'd0;
    ice_y     = 9'd0;
    ice_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expectNext("edge_no_false_hit", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
      applyStimulus(1);
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]: observed %h expected %h", e.tag, i, outVec(), e.v);
      end
    end
    ice_x = 10'd650;
    ice_y = 9'd500;
    expectNext("edge_lat1", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
    expectNext("edge_wide_hit", mk(1, 1, 1, 0, 0, 7'd127, 8'd1));
    expectNext("edge_hold", mk(1, 1, 0, 0, 0, 7'd127, 8'd1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      ice_valid = 1'b0;
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    doReset();
    ice_x     = 10'd250;
    ice_y     = 9'd280;
    ice_valid = 1'b1;
    ply_x     = 10'd230;
    ply_y     = 9'd270;
    expectNext("same_cycle_lat1", mk(0, 1, 0, 0, 0, 7'd0, 8'd0));
    expectNext("same_cycle_freeze_wins", mk(1, 1, 1, 0, 0, 7'd127, 8'd1));
    expectNext("same_cycle_hold", mk(1, 1, 0, 0, 0, 7'd127, 8'd1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      ice_valid = 1'b0;
      ply_x     = 10'd0;
      ply_y     = 9'd0;
      e = sbQ.pop_front();
      vectorsApplied++;
      if (outVec() !== e.v) begin
        miscompares++;
        $display("[TB] FAIL %s: observed %h expected %h", e.tag, outVec(), e.v);
      end
    end
  endtask

  // Test sequence; later tests rely on the state left by earlier ones
  initial begin
    rst = 1'b1;
    setIdle();
    test_reset();
    test_freeze();
    test_thaw();
    test_refreeze();
    test_shatter();
    test_reset_mid_frozen();
    test_contact();
    test_boundary_x();
    test_edge_wrap();
    test_same_cycle();
    vectorsApplied++;
    if (sbQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drained: observed %0d entries expected 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
